// File: rtl/matrix_mult_pkg.sv
// Shared state encodings and width helpers for the streaming matrix multiplier.
package matrix_mult_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_A  = 3'd1;
  localparam logic [2:0] LOAD_B  = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] OUTPUT  = 3'd4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int s = 0; s < 31; s++) begin
      if ((1 << s) < v) r = s + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_mult_stream_mac.sv
// Registered multiply-accumulate: operands extended to AW, product and sum kept at AW.
module matrix_mult_stream_mac
  import matrix_mult_pkg::*;
#(
  parameter int W      = 4,
  parameter int AW     = 9,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          clr_acc,
  input  logic          en,
  output logic [AW-1:0] acc,
  output logic [AW-1:0] acc_nxt
);

  logic [AW-1:0] a_ext;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] prod;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{(AW-W){a[W-1]}}, a};
      b_ext = {{(AW-W){b[W-1]}}, b};
    end else begin
      a_ext = {{(AW-W){1'b0}}, a};
      b_ext = {{(AW-W){1'b0}}, b};
    end
    // modulo-2^AW arithmetic is exact for both signednesses since AW covers the full range
    prod    = a_ext * b_ext;
    acc_nxt = (clr_acc ? '0 : acc) + prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end else if (clr_acc) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming N x N matrix multiplier: load A, load B, compute with one shared MAC, drain C.
//   state   | meaning
//   IDLE    | one cycle after reset release
//   LOAD_A  | accepting A row-major
//   LOAD_B  | accepting B row-major
//   COMPUTE | N^3 MAC cycles, i/j/k with k innermost
//   OUTPUT  | presenting C row-major
module matrix_mult_stream
  import matrix_mult_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int W      = 4,
  parameter  int SIGNED = 0,
  localparam int AW     = 2*W + clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int NN = N*N;
  localparam int CW = clog2(N);
  localparam int LW = clog2(NN);

  logic [2:0]    state;
  logic [LW-1:0] cnt;
  logic [CW-1:0] i_cnt, j_cnt, k_cnt;
  logic [W-1:0]  a_mem [NN];
  logic [W-1:0]  b_mem [NN];
  logic [AW-1:0] c_mem [NN];
  logic [LW-1:0] a_idx, b_idx, c_idx;
  logic          last_cnt, last_i, last_j, last_k;
  logic          mac_en, mac_clr;
  logic [AW-1:0] acc, acc_nxt;

  assign a_idx    = LW'(i_cnt) * LW'(N) + LW'(k_cnt);
  assign b_idx    = LW'(k_cnt) * LW'(N) + LW'(j_cnt);
  assign c_idx    = LW'(i_cnt) * LW'(N) + LW'(j_cnt);
  assign last_cnt = (cnt == LW'(NN-1));
  assign last_i   = (i_cnt == CW'(N-1));
  assign last_j   = (j_cnt == CW'(N-1));
  assign last_k   = (k_cnt == CW'(N-1));
  assign mac_en   = (state == COMPUTE) && !clear;
  assign mac_clr  = clear || (k_cnt == '0);

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state == COMPUTE) || (state == OUTPUT);
  assign out_data  = (state == OUTPUT) ? c_mem[cnt] : '0;

  matrix_mult_stream_mac #(.W(W), .AW(AW), .SIGNED(SIGNED)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_mem[a_idx]),
    .b       (b_mem[b_idx]),
    .clr_acc (mac_clr),
    .en      (mac_en),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
    end else if (clear) begin
      state <= LOAD_A;
      cnt   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD_A;
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            if (last_cnt) begin
              cnt   <= '0;
              state <= (state == LOAD_A) ? LOAD_B : COMPUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (!last_k) begin
            k_cnt <= k_cnt + 1'b1;
          end else begin
            k_cnt <= '0;
            if (!last_j) begin
              j_cnt <= j_cnt + 1'b1;
            end else begin
              j_cnt <= '0;
              if (!last_i) begin
                i_cnt <= i_cnt + 1'b1;
              end else begin
                i_cnt <= '0;
                state <= OUTPUT;
              end
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (last_cnt) begin
              cnt   <= '0;
              state <= LOAD_A;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // operand/result storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (!clear && in_valid && state == LOAD_A) a_mem[cnt] <= in_data;
    if (!clear && in_valid && state == LOAD_B) b_mem[cnt] <= in_data;
    if (mac_en && last_k) c_mem[c_idx] <= acc_nxt;
  end

endmodule
